// File: rtl/notch_stream_checker.sv
// notch_stream_checker: response checker at the consumer end of the notch filter stream.
// Holds a preloaded table of expected samples. After a start request it discards LATENCY
// enabled samples, then compares DEPTH enabled samples of y_n against the table. It keeps
// match/error counts, captures the first failing index and reports pass/fail.
//
// Optional feature macro: CHECKER_TOLERANCE_EN
//   defined   : a sample matches when |y_n - mem[idx]| <= TOL
//   undefined : bit-exact match, TOL unused, no subtractor
//
// Ports:
//   CLK             clock, rising edge
//   rst_n           asynchronous active-low reset
//   enable          sample strobe (shared with the filter enable)
//   y_n             filter output sample, signed WIDTH bits
//   start           single-cycle run request (ignored while busy)
//   wr_en           expected-table write strobe (IDLE/DONE only)
//   wr_addr         table write address
//   wr_data         expected sample to write
//   busy            high while aligning or checking
//   done            high once a run has completed
//   pass            high in DONE when no mismatch was seen
//   match_cnt       saturating count of matching samples
//   err_cnt         saturating count of mismatching samples
//   err_pulse       one-cycle pulse per mismatch
//   first_err_valid a mismatch has been captured in this run
//   first_err_idx   index of the first mismatch
module notch_stream_checker #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 6712,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TOL     = 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [WIDTH-1:0]  y_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_pulse,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_idx
);

  localparam int unsigned SkipW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  // Extended by one bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StAlign, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [SkipW-1:0]  skip_q, skip_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              err_pulse_q, err_pulse_d;
  logic              fev_q, fev_d;
  logic [ADDR_W-1:0] fei_q, fei_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  expected;
  logic              sample_ok;
  logic              wr_ok;

  assign expected = mem[idx_q];

`ifdef CHECKER_TOLERANCE_EN
  // One extra bit keeps the difference of two WIDTH-bit signed values exact.
  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] abs_diff;
  assign diff      = $signed({y_n[WIDTH-1], y_n}) - $signed({expected[WIDTH-1], expected});
  assign abs_diff  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign sample_ok = (abs_diff <= (WIDTH + 1)'(TOL));
`else
  assign sample_ok = (y_n == expected);
`endif

  // Table writes are locked out while a run is in flight.
  assign wr_ok = wr_en && ((state_q == StIdle) || (state_q == StDone)) &&
                 ({1'b0, wr_addr} < DepthExt);

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    idx_d       = idx_q;
    match_d     = match_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    fev_d       = fev_q;
    fei_d       = fei_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          match_d = '0;
          err_d   = '0;
          idx_d   = '0;
          fev_d   = 1'b0;
          fei_d   = '0;
          skip_d  = SkipW'(LATENCY);
          state_d = (LATENCY == 0) ? StCheck : StAlign;
        end
      end
      StAlign: begin
        if (enable) begin
          skip_d = skip_q - 1'b1;
          if (skip_q == SkipW'(1)) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (enable) begin
          if (sample_ok) begin
            if (match_q != '1) match_d = match_q + 1'b1;
          end else begin
            if (err_q != '1) err_d = err_q + 1'b1;
            err_pulse_d = 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx_q;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      skip_q      <= '0;
      idx_q       <= '0;
      match_q     <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
      fev_q       <= 1'b0;
      fei_q       <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      fev_q       <= fev_d;
      fei_q       <= fei_d;
    end
  end

  assign busy            = (state_q == StAlign) || (state_q == StCheck);
  assign done            = (state_q == StDone);
  assign pass            = done && (err_q == '0);
  assign match_cnt       = match_q;
  assign err_cnt         = err_q;
  assign err_pulse       = err_pulse_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_notch_stream_checker.sv
// Testbench for notch_stream_checker: directed runs checked every cycle against a
// sample-counting model of the checker, plus literal expectations per scenario.
module tb_notch_stream_checker;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 14;
  localparam int LATENCY = 1;
  localparam int TOL     = 1;

  logic              CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [WIDTH-1:0]  y_n = '0;
  logic              start = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              busy, done, pass, err_pulse, first_err_valid;
  logic [CNT_W-1:0]  match_cnt, err_cnt;
  logic [ADDR_W-1:0] first_err_idx;

  notch_stream_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .LATENCY(LATENCY), .TOL(TOL)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .y_n(y_n), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .pass(pass), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .err_pulse(err_pulse), .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit check_en = 1'b0;

  // Model: counts enabled samples since start; sample n >= LATENCY is compared
  // against table entry n - LATENCY.
  int exp_mem [DEPTH];
  bit m_busy, m_done, m_pulse, m_fev;
  int m_match, m_err, m_fei, m_seen;
  int ys [DEPTH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sample_matches(input int y, input int e);
`ifdef CHECKER_TOLERANCE_EN
    int d = y - e;
    if (d < 0) d = -d;
    return d <= TOL;
`else
    return y == e;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pulse = 0; m_fev = 0;
    m_match = 0; m_err = 0; m_fei = 0; m_seen = 0;
  endtask

  // Called right after a rising edge; inputs still hold the values the DUT sampled.
  task automatic model_edge();
    bit wr_ok = wr_en && !m_busy && (int'(wr_addr) < DEPTH);
    int k;
    m_pulse = 0;
    if (m_busy && enable) begin
      if (m_seen >= LATENCY) begin
        k = m_seen - LATENCY;
        if (sample_matches(int'($signed(y_n)), exp_mem[k])) begin
          if (m_match < 2**CNT_W - 1) m_match++;
        end else begin
          if (m_err < 2**CNT_W - 1) m_err++;
          m_pulse = 1;
          if (!m_fev) begin
            m_fev = 1;
            m_fei = k;
          end
        end
        if (k == DEPTH - 1) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      m_seen++;
    end else if (!m_busy && start) begin
      m_busy = 1; m_done = 0; m_match = 0; m_err = 0; m_fev = 0; m_fei = 0; m_seen = 0;
    end
    if (wr_ok) exp_mem[wr_addr] = int'($signed(wr_data));
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("pass", int'(pass), int'(m_done && (m_err == 0)));
      chk("match_cnt", int'(match_cnt), m_match);
      chk("err_cnt", int'(err_cnt), m_err);
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("first_err_valid", int'(first_err_valid), int'(m_fev));
      chk("first_err_idx", int'(first_err_idx), m_fei);
      if (err_pulse) pulse_cnt++;
    end
  end

  task automatic step(input bit en, input int y, input bit st = 0,
                      input bit we = 0, input int wa = 0, input int wd = 0);
    enable  = en;
    y_n     = WIDTH'(y);
    start   = st;
    wr_en   = we;
    wr_addr = ADDR_W'(wa);
    wr_data = WIDTH'(wd);
    @(posedge CLK);
    model_edge();
    #1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;
  endtask

  // Continuous run: start (optionally with a write), dummy sample, then ys[0..DEPTH-1].
  task automatic run(input bit we = 0, input int wa = 0, input int wd = 0);
    step(0, 0, 1, we, wa, wd);
    chk("busy_after_start", int'(busy), 1);
    step(1, 1234);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, ys[i]);
      if (i == DEPTH - 2) chk("done_early", int'(done), 0);
    end
    chk("done_timing", int'(done), 1);
  endtask

  task automatic ys_ramp();
    for (int i = 0; i < DEPTH; i++) ys[i] = i;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 0;
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match", int'(match_cnt), 0);

    // Load table 0..15, exact run.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i, i);
    ys_ramp();
    run();
    chk("r1_match", int'(match_cnt), 16);
    chk("r1_err", int'(err_cnt), 0);
    chk("r1_pass", int'(pass), 1);

    // Two mismatches.
    ys_ramp();
    ys[5] = 99;
    ys[9] = -3;
    pulse_cnt = 0;
    run();
    chk("r2_err", int'(err_cnt), 2);
    chk("r2_match", int'(match_cnt), 14);
    chk("r2_fei", int'(first_err_idx), 5);
    chk("r2_fev", int'(first_err_valid), 1);
    chk("r2_pulses", pulse_cnt, 2);
    chk("r2_pass", int'(pass), 0);

    // Enable toggling: gaps carry garbage that must be ignored.
    step(0, 0, 1);
    step(1, 1234);
    step(0, 555);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, i);
      if (i < DEPTH - 1) step(0, 555);
    end
    chk("r3_done", int'(done), 1);
    chk("r3_match", int'(match_cnt), 16);
    chk("r3_pass", int'(pass), 1);

    // Reset mid-CHECK, then a fresh run on the retained table.
    step(0, 0, 1);
    step(1, 1234);
    for (int i = 0; i < 6; i++) step(1, i);
    do_reset();
    chk("r4_busy", int'(busy), 0);
    chk("r4_match", int'(match_cnt), 0);
    chk("r4_done", int'(done), 0);
    ys_ramp();
    run();
    chk("r4_pass", int'(pass), 1);

    // Write and start while busy are both dropped.
    step(0, 0, 1);
    step(1, 1234);
    for (int i = 0; i < 3; i++) step(1, i);
    step(1, 3, 1, 1, 3, 777);
    for (int i = 4; i < DEPTH; i++) step(1, i);
    chk("r5_done", int'(done), 1);
    chk("r5_match", int'(match_cnt), 16);
    ys_ramp();
    run();
    chk("r5_table", int'(pass), 1);

    // Off-by-one samples: +1 and -2.
    ys_ramp();
    ys[2] = 3;
    ys[7] = 5;
    run();
`ifdef CHECKER_TOLERANCE_EN
    chk("r6_match", int'(match_cnt), 15);
    chk("r6_err", int'(err_cnt), 1);
    chk("r6_fei", int'(first_err_idx), 7);
`else
    chk("r6_match", int'(match_cnt), 14);
    chk("r6_err", int'(err_cnt), 2);
    chk("r6_fei", int'(first_err_idx), 2);
`endif

    // Write and start in the same DONE cycle: write lands, run begins.
    ys_ramp();
    ys[0] = 50;
    run(1, 0, 50);
    chk("r7_pass", int'(pass), 1);
    chk("r7_match", int'(match_cnt), 16);

    step(0, 0);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
